register_file_sb: RTL and testbench

Parametrised register file with an integrated write-pending scoreboard, for the pipelined RISC-V core. It provides two combinational read ports and one write port, and tracks which destination registers have an instruction in flight. Decode uses the busy flags to stall on RAW hazards. Writeback clears each busy flag as it commits the data.

---
 rtl/regfile_pkg.sv | 11 +
 rtl/regfile_scoreboard.sv | 59 +++++
 rtl/register_file_sb.sv | 80 ++++++++
 tb/tb_register_file_sb.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the register file with write-pending scoreboard.
package regfile_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int AW_DEF   = $clog2(NREG_DEF);
  localparam int ZERO_REG = 0;

  typedef logic [AW_DEF-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-vector scoreboard: tracks registers with an in-flight writer, gates issue
// on WAW hazards and keeps a registered count of pending registers.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int NREG = NREG_DEF,
  localparam int AW   = $clog2(NREG)
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_rd,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  output logic [NREG-1:0] busy,
  output logic            iss_ready,
  output logic [AW:0]     pending_cnt
);

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_next;
  logic [AW:0]     r_cnt;
  logic [AW:0]     w_cnt_next;
  logic            w_iss_nz;
  logic            w_wb_nz;
  logic            w_set;
  logic            w_clr;
  logic            w_dec;

  assign w_iss_nz  = (iss_rd != AW'(ZERO_REG));
  assign w_wb_nz   = (wb_addr != AW'(ZERO_REG));
  // A pending destination may be re-issued only when its writeback retires this cycle.
  assign iss_ready = !(iss_en && w_iss_nz && r_busy[iss_rd]) || (wb_en && (wb_addr == iss_rd));
  assign w_set     = iss_en && iss_ready && w_iss_nz;
  assign w_clr     = wb_en && w_wb_nz;
  assign w_dec     = w_clr && r_busy[wb_addr];

  // Set has priority over clear so a same-register issue/writeback leaves the bit busy.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
    assign w_busy_next[gi] = (w_set && (iss_rd == AW'(gi))) ||
                             (r_busy[gi] && !(w_clr && (wb_addr == AW'(gi))));
  end

  assign w_cnt_next = r_cnt + {{AW{1'b0}}, w_set} - {{AW{1'b0}}, w_dec};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      r_busy <= w_busy_next;
      r_cnt  <= w_cnt_next;
    end
  end

  assign busy        = r_busy;
  assign pending_cnt = r_cnt;

endmodule

// File: rtl/register_file_sb.sv
// Two-read/one-write register file with integrated write-pending scoreboard.
// Optional same-cycle writeback-to-read bypass enabled by REGFILE_BYPASS_EN.
module register_file_sb
  import regfile_pkg::*;
#(
  parameter  int XLEN = XLEN_DEF,
  parameter  int NREG = NREG_DEF,
  localparam int AW   = $clog2(NREG)
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_rd,
  output logic            iss_ready,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic [AW:0]     pending_cnt
);

  logic [XLEN-1:0] r_mem [NREG];
  logic [NREG-1:0] w_busy;
  logic [AW-1:0]   w_raddr [2];
  logic [XLEN-1:0] w_rdata [2];
  logic            w_rbusy [2];
  logic            w_wb_we;

  regfile_scoreboard #(
    .NREG (NREG)
  ) u_scoreboard (
    .clock       (clock),
    .reset_n     (reset_n),
    .iss_en      (iss_en),
    .iss_rd      (iss_rd),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .busy        (w_busy),
    .iss_ready   (iss_ready),
    .pending_cnt (pending_cnt)
  );

  assign w_wb_we = wb_en && (wb_addr != AW'(ZERO_REG));

  // Entry 0 is never written, so it holds its reset value of zero.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    end else if (w_wb_we) begin
      r_mem[wb_addr] <= wb_data;
    end
  end

  assign w_raddr[0] = rs1_addr;
  assign w_raddr[1] = rs2_addr;

  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    logic w_nz;
    logic w_byp;
    assign w_nz = (w_raddr[gi] != AW'(ZERO_REG));
`ifdef REGFILE_BYPASS_EN
    assign w_byp = w_wb_we && (wb_addr == w_raddr[gi]);
`else
    assign w_byp = 1'b0;
`endif
    assign w_rdata[gi] = !w_nz ? '0 : (w_byp ? wb_data : r_mem[w_raddr[gi]]);
    assign w_rbusy[gi] = w_nz && !w_byp && w_busy[w_raddr[gi]];
  end

  assign rs1_data = w_rdata[0];
  assign rs2_data = w_rdata[1];
  assign rs1_busy = w_rbusy[0];
  assign rs2_busy = w_rbusy[1];

endmodule

// File: tb/tb_register_file_sb.sv
// Scoreboard testbench for register_file_sb: directed scenarios plus random traffic
// checked against a behavioural register/busy model.
module tb_register_file_sb;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic            clock;
  logic            reset_n;
  logic [AW-1:0]   rs1_addr, rs2_addr;
  logic [XLEN-1:0] rs1_data, rs2_data;
  logic            rs1_busy, rs2_busy;
  logic            iss_en;
  logic [AW-1:0]   iss_rd;
  logic            iss_ready;
  logic            wb_en;
  logic [AW-1:0]   wb_addr;
  logic [XLEN-1:0] wb_data;
  logic [AW:0]     pending_cnt;

  register_file_sb #(.XLEN(XLEN), .NREG(NREG)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .iss_en      (iss_en),
    .iss_rd      (iss_rd),
    .iss_ready   (iss_ready),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .pending_cnt (pending_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int          id;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        b1;
    logic        b2;
    logic        rdy;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   txn    = 0;

  // Reference model: architectural view only.
  logic [31:0] m_data [NREG];
  bit          m_busy [NREG];

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < NREG; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < NREG; i++) begin
      m_data[i] = '0;
      m_busy[i] = 1'b0;
    end
  endfunction

  function automatic void m_read(input int a, output logic [31:0] d, output logic b);
    d = m_data[a];
    b = m_busy[a];
    if (a == 0) begin
      d = '0;
      b = 1'b0;
    end
`ifdef REGFILE_BYPASS_EN
    else if (wb_en && int'(wb_addr) == a) begin
      d = wb_data;
      b = 1'b0;
    end
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp, input int id);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL txn %0d %s: got %h expected %h", id, name, act, exp);
    end
  endtask

  // One clock of stimulus: drive, predict, enqueue, then advance the model at the edge.
  task automatic step(input bit rst, input bit ie, input int ird, input bit we,
                      input int wa, input logic [31:0] wd, input int a1, input int a2);
    exp_t e;
    bit   rdy;
    reset_n  = !rst;
    iss_en   = ie;
    iss_rd   = AW'(ird);
    wb_en    = we;
    wb_addr  = AW'(wa);
    wb_data  = wd;
    rs1_addr = AW'(a1);
    rs2_addr = AW'(a2);
    if (rst) m_clear();
    rdy = 1'b1;
    if (ie && ird != 0 && m_busy[ird] && !(we && wa == ird)) rdy = 1'b0;
    e.id  = txn;
    m_read(a1, e.d1, e.b1);
    m_read(a2, e.d2, e.b2);
    e.rdy = rdy;
    e.cnt = 32'(m_count());
    exp_q.push_back(e);
    txn++;
    @(posedge clock);
    if (!rst) begin
      if (we && wa != 0) begin
        m_data[wa] = wd;
        m_busy[wa] = 1'b0;
      end
      if (ie && rdy && ird != 0) m_busy[ird] = 1'b1;
    end
    #1;
  endtask

  task automatic idle(input int a1, input int a2);
    step(0, 0, 0, 0, 0, '0, a1, a2);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rs1_data", rs1_data, e.d1, e.id);
        chk("rs1_busy", 32'(rs1_busy), 32'(e.b1), e.id);
        chk("rs2_data", rs2_data, e.d2, e.id);
        chk("rs2_busy", 32'(rs2_busy), 32'(e.b2), e.id);
        chk("iss_ready", 32'(iss_ready), 32'(e.rdy), e.id);
        chk("pending_cnt", 32'(pending_cnt), e.cnt, e.id);
        $display("txn %0d: rs1=%h/%0d rs2=%h/%0d rdy=%0d cnt=%0d", e.id,
                 rs1_data, rs1_busy, rs2_data, rs2_busy, iss_ready, pending_cnt);
      end
    end
  end

  initial begin : stimulus
    int wait_cycles;
    reset_n = 1'b0; iss_en = 0; iss_rd = '0; wb_en = 0; wb_addr = '0; wb_data = '0;
    rs1_addr = '0; rs2_addr = '0;
    m_clear();
    @(posedge clock);
    #1;
    step(1, 0, 0, 0, 0, '0, 5, 0);                 // reset state
    idle(5, 0);
    step(0, 0, 0, 1, 0, 32'hDEADBEEF, 0, 0);       // write to r0 is a no-op
    idle(0, 0);
    step(0, 1, 7, 0, 0, '0, 7, 0);                 // issue r7
    idle(7, 0);
    step(0, 1, 7, 0, 0, '0, 7, 0);                 // WAW refused
    step(0, 0, 0, 1, 7, 32'h12345678, 7, 7);       // writeback r7
    idle(7, 7);
    step(0, 1, 3, 1, 3, 32'h000000A5, 3, 3);       // same-register issue + wb
    idle(3, 3);
    step(0, 1, 3, 1, 3, 32'h000000B6, 3, 0);       // re-issue busy r3 with its own wb
    step(0, 1, 4, 1, 3, 32'h000000C7, 4, 3);       // different registers
    idle(4, 3);
    step(0, 1, 9, 0, 0, '0, 0, 9);
    step(0, 0, 0, 1, 9, 32'h00000055, 0, 9);       // bypass case
    idle(9, 9);
    step(0, 1, 0, 1, 4, 32'h11111111, 4, 0);       // issue r0 always accepted
    step(1, 0, 0, 0, 0, '0, 1, 2);
    for (int r = 1; r < NREG; r++) step(0, 1, r, 0, 0, '0, r, r - 1);
    idle(31, 1);                                   // full scoreboard
    step(0, 1, 12, 0, 0, '0, 12, 0);               // refused at saturation
    step(1, 0, 0, 0, 0, '0, 31, 1);                // asynchronous mid-run reset
    idle(31, 1);
    for (int i = 0; i < 500; i++) begin
      int  lim;
      lim = ($urandom_range(0, 3) == 0) ? NREG - 1 : 7;
      step(($urandom_range(0, 99) == 0), $urandom_range(0, 1), $urandom_range(0, lim),
           $urandom_range(0, 1), $urandom_range(0, lim), $urandom(),
           $urandom_range(0, lim), $urandom_range(0, lim));
    end
    idle(0, 0);
    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 20) begin
      @(posedge clock);
      wait_cycles++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
